// File: rtl/grid_axil_pkg.sv
// Shared constants and sizing helpers for the grid AXI4-Lite register bank.
package grid_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Width of a register select; a one-register bank still needs one bit.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/grid_axil_regbank_if.sv
// AXI4-Lite bus bundle between the PS interconnect (master) and the register bank (slave).
interface grid_axil_regbank_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, input S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, input S_AXI_WREADY,
        input S_AXI_BRESP, S_AXI_BVALID, output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, input S_AXI_ARREADY,
        input S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, output S_AXI_RREADY
    );

    modport slave (
        input S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, output S_AXI_AWREADY,
        input S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID, input S_AXI_BREADY,
        input S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, input S_AXI_RREADY
    );

endinterface

// File: rtl/grid_axil_wstrb_merge.sv
// Byte-lane merge of write data over the current register value.
module grid_axil_wstrb_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_data,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    output logic [DW-1:0]   new_data
);
    always_comb begin
        new_data = old_data;
        for (int b = 0; b < DW / 8; b++) begin
            if (wstrb[b]) new_data[b*8 +: 8] = wdata[b*8 +: 8];
        end
    end
endmodule

// File: rtl/grid_axil_regbank.sv
// Parametrised AXI4-Lite register bank: RW/RO registers, byte strobes,
// hardware load ports and per-register write pulses.
module grid_axil_regbank
    import grid_axil_pkg::*;
#(
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_S_AXI_ADDR_WIDTH = 6,
    parameter int                            NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0]           RO_MASK            = '0,
    parameter logic [C_S_AXI_DATA_WIDTH-1:0] RESET_VAL          = '0
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    grid_axil_regbank_if.slave                     s_axi,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_d,
    input  logic [NUM_REGS-1:0]                    hw_we
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int OFF   = byte_off_bits(DW);
    localparam int SEL_W = idx_width(NUM_REGS);

    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [DW/8-1:0] w_strb_q, w_strb_d;
    logic            awready_q, awready_d, wready_q, wready_d;
    logic            bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]      bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic             commit, w_in_range, w_ok, r_in_range;
    logic [31:0]      w_idx, r_idx;
    logic [SEL_W-1:0] w_sel, r_sel;
    logic [DW-1:0]    w_old, w_new;
    logic             unused_prot;

    assign commit     = aw_held_q && w_held_q;
    assign w_idx      = 32'(aw_addr_q >> OFF);
    assign w_in_range = w_idx < 32'(NUM_REGS);
    assign w_sel      = w_idx[SEL_W-1:0];
    assign w_ok       = w_in_range && !RO_MASK[w_sel];
    assign w_old      = w_in_range ? regs_q[w_sel] : '0;
    assign r_idx      = 32'(s_axi.S_AXI_ARADDR >> OFF);
    assign r_in_range = r_idx < 32'(NUM_REGS);
    assign r_sel      = r_idx[SEL_W-1:0];

    // One merge unit for the whole bank, fed by the addressed register.
    grid_axil_wstrb_merge #(.DW(DW)) u_merge (
        .old_data (w_old),
        .wdata    (w_data_q),
        .wstrb    (w_strb_q),
        .new_data (w_new)
    );

    always_comb begin
        aw_held_d    = aw_held_q;
        aw_addr_d    = aw_addr_q;
        w_held_d     = w_held_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        regs_d       = regs_q;
        reg_wr_pulse = '0;
        if (s_axi.S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi.S_AXI_AWADDR;
        end
        if (s_axi.S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = s_axi.S_AXI_WDATA;
            w_strb_d = s_axi.S_AXI_WSTRB;
        end
        if (bvalid_q && s_axi.S_AXI_BREADY) bvalid_d = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hw_we[i]) regs_d[i] = hw_d[i*DW +: DW];
        end
        // The AXI commit is applied after the hardware loads so it wins on RW registers.
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = w_ok ? RESP_OKAY : RESP_SLVERR;
            if (w_ok) begin
                reg_wr_pulse[w_sel] = 1'b1;
                regs_d[w_sel]       = w_new;
            end
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (s_axi.S_AXI_ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = r_in_range ? regs_q[r_sel] : '0;
            rresp_d  = r_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign reg_q               = regs_q;
    assign unused_prot         = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

endmodule

// File: tb/tb_grid_axil_regbank.sv
// Directed scoreboard bench over three bank configurations sharing one stimulus bus.
module tb_grid_axil_regbank;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct { logic [63:0] data; logic [1:0] resp; } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   sel = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]   aw_addr = '0, ar_addr = '0, w_strb = '0, hw_we = '0;
    logic         aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
    logic [63:0]  w_data = '0;
    logic [255:0] hw_d32 = '0;
    logic [511:0] hw_d64 = '0;

    logic            awready, wready, bvalid, arready, rvalid;
    logic [1:0]      bresp, rresp;
    logic [63:0]     rdata;
    logic [7:0]      pulse;
    logic [7:0][63:0] regv;

    logic [255:0] rq_a, rq_b;
    logic [511:0] rq_c;
    logic [7:0]   pl_a, pl_b, pl_c;

    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    int          pcnt[8];
    int          snap[8];

    always #5 clk = ~clk;

    grid_axil_regbank_if #(.DW(32), .AW(7)) if_a ();
    grid_axil_regbank_if #(.DW(32), .AW(6)) if_b ();
    grid_axil_regbank_if #(.DW(64), .AW(6)) if_c ();

    assign if_a.S_AXI_AWADDR = aw_addr[6:0];   assign if_b.S_AXI_AWADDR = aw_addr[5:0];   assign if_c.S_AXI_AWADDR = aw_addr[5:0];
    assign if_a.S_AXI_ARADDR = ar_addr[6:0];   assign if_b.S_AXI_ARADDR = ar_addr[5:0];   assign if_c.S_AXI_ARADDR = ar_addr[5:0];
    assign if_a.S_AXI_AWPROT = 3'b000;         assign if_b.S_AXI_AWPROT = 3'b000;         assign if_c.S_AXI_AWPROT = 3'b000;
    assign if_a.S_AXI_ARPROT = 3'b000;         assign if_b.S_AXI_ARPROT = 3'b000;         assign if_c.S_AXI_ARPROT = 3'b000;
    assign if_a.S_AXI_AWVALID = aw_valid && sel == 0;
    assign if_b.S_AXI_AWVALID = aw_valid && sel == 1;
    assign if_c.S_AXI_AWVALID = aw_valid && sel == 2;
    assign if_a.S_AXI_WVALID  = w_valid && sel == 0;
    assign if_b.S_AXI_WVALID  = w_valid && sel == 1;
    assign if_c.S_AXI_WVALID  = w_valid && sel == 2;
    assign if_a.S_AXI_ARVALID = ar_valid && sel == 0;
    assign if_b.S_AXI_ARVALID = ar_valid && sel == 1;
    assign if_c.S_AXI_ARVALID = ar_valid && sel == 2;
    assign if_a.S_AXI_WDATA = w_data[31:0];    assign if_b.S_AXI_WDATA = w_data[31:0];    assign if_c.S_AXI_WDATA = w_data;
    assign if_a.S_AXI_WSTRB = w_strb[3:0];     assign if_b.S_AXI_WSTRB = w_strb[3:0];     assign if_c.S_AXI_WSTRB = w_strb;
    assign if_a.S_AXI_BREADY = b_ready;        assign if_b.S_AXI_BREADY = b_ready;        assign if_c.S_AXI_BREADY = b_ready;
    assign if_a.S_AXI_RREADY = r_ready;        assign if_b.S_AXI_RREADY = r_ready;        assign if_c.S_AXI_RREADY = r_ready;

    grid_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .NUM_REGS(8),
                        .RO_MASK(8'h00), .RESET_VAL(32'h0)) dut_a (
        .ACLK(clk), .ARESET(rst), .s_axi(if_a), .reg_q(rq_a), .reg_wr_pulse(pl_a),
        .hw_d(hw_d32), .hw_we(sel == 0 ? hw_we : 8'h00));
    grid_axil_regbank #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(8),
                        .RO_MASK(8'h02), .RESET_VAL(32'h0000_5A5A)) dut_b (
        .ACLK(clk), .ARESET(rst), .s_axi(if_b), .reg_q(rq_b), .reg_wr_pulse(pl_b),
        .hw_d(hw_d32), .hw_we(sel == 1 ? hw_we : 8'h00));
    grid_axil_regbank #(.C_S_AXI_DATA_WIDTH(64), .C_S_AXI_ADDR_WIDTH(6), .NUM_REGS(8),
                        .RO_MASK(8'h00), .RESET_VAL(64'h0)) dut_c (
        .ACLK(clk), .ARESET(rst), .s_axi(if_c), .reg_q(rq_c), .reg_wr_pulse(pl_c),
        .hw_d(hw_d64), .hw_we(sel == 2 ? hw_we : 8'h00));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            case (sel)
                0:       regv[i] = 64'(rq_a[i*32 +: 32]);
                1:       regv[i] = 64'(rq_b[i*32 +: 32]);
                default: regv[i] = rq_c[i*64 +: 64];
            endcase
        end
        case (sel)
            0: begin
                awready = if_a.S_AXI_AWREADY; wready = if_a.S_AXI_WREADY; bvalid = if_a.S_AXI_BVALID;
                bresp = if_a.S_AXI_BRESP; arready = if_a.S_AXI_ARREADY; rvalid = if_a.S_AXI_RVALID;
                rdata = 64'(if_a.S_AXI_RDATA); rresp = if_a.S_AXI_RRESP; pulse = pl_a;
            end
            1: begin
                awready = if_b.S_AXI_AWREADY; wready = if_b.S_AXI_WREADY; bvalid = if_b.S_AXI_BVALID;
                bresp = if_b.S_AXI_BRESP; arready = if_b.S_AXI_ARREADY; rvalid = if_b.S_AXI_RVALID;
                rdata = 64'(if_b.S_AXI_RDATA); rresp = if_b.S_AXI_RRESP; pulse = pl_b;
            end
            default: begin
                awready = if_c.S_AXI_AWREADY; wready = if_c.S_AXI_WREADY; bvalid = if_c.S_AXI_BVALID;
                bresp = if_c.S_AXI_BRESP; arready = if_c.S_AXI_ARREADY; rvalid = if_c.S_AXI_RVALID;
                rdata = if_c.S_AXI_RDATA; rresp = if_c.S_AXI_RRESP; pulse = pl_c;
            end
        endcase
    end

    always @(negedge clk) begin
        for (int i = 0; i < 8; i++) if (pulse[i]) pcnt[i] <= pcnt[i] + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 8; i++) snap[i] = pcnt[i];
    endtask

    function automatic logic [63:0] pulse_delta();
        logic [63:0] d = '0;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(pcnt[i] - snap[i]);
        return d;
    endfunction

    task automatic b_collect(input string tag);
        int t = 0;
        logic [1:0] e;
        while (!bvalid && t < 50) begin step(); t++; end
        chk({tag, "_bvalid"}, 64'(bvalid), 64'(1));
        e = exp_b.pop_front();
        chk({tag, "_bresp"}, 64'(bresp), 64'(e));
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input logic [1:0] resp, input string tag);
        int t = 0;
        logic aw_acc, w_acc;
        exp_b.push_back(resp);
        aw_addr = addr; w_data = data; w_strb = strb;
        aw_valid = 1'b1; w_valid = 1'b1;
        while ((aw_valid || w_valid) && t < 50) begin
            aw_acc = aw_valid && awready;
            w_acc  = w_valid && wready;
            step();
            if (aw_acc) aw_valid = 1'b0;
            if (w_acc)  w_valid = 1'b0;
            t++;
        end
        chk({tag, "_accept"}, 64'({aw_valid, w_valid}), 64'(0));
        aw_valid = 1'b0; w_valid = 1'b0;
        b_collect(tag);
    endtask

    task automatic axi_read(input logic [7:0] addr, input logic [63:0] data,
                            input logic [1:0] resp, input string tag);
        int t = 0;
        rexp_t e;
        exp_r.push_back('{data: data, resp: resp});
        ar_addr = addr; ar_valid = 1'b1;
        while (!arready && t < 50) begin step(); t++; end
        step();
        ar_valid = 1'b0;
        t = 0;
        while (!rvalid && t < 50) begin step(); t++; end
        chk({tag, "_rvalid"}, 64'(rvalid), 64'(1));
        e = exp_r.pop_front();
        chk({tag, "_rdata"}, rdata, e.data);
        chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
        r_ready = 1'b1;
        step();
        r_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pcnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state of bank A, then reset values of bank B (RW vs RO).
        chk("rst_ready", 64'({awready, wready, arready}), 64'(0));
        chk("rst_valid", 64'({bvalid, rvalid}), 64'(0));
        chk("rst_resp", 64'({bresp, rresp}), 64'(0));
        chk("rst_rdata", rdata, 64'(0));
        chk("rst_pulse", 64'(pulse), 64'(0));
        chk("rst_a_r0", regv[0], 64'(0));
        sel = 1;
        #1;
        chk("rst_b_rw0", regv[0], 64'h5A5A);
        chk("rst_b_ro1", regv[1], 64'(0));
        sel = 0;
        rst = 1'b0;
        step();
        step();

        // Bank A: basic writes and read-back.
        take_snap();
        axi_write(8'h00, 64'h1, 8'hF, OKAY, "wr0");
        axi_write(8'h04, 64'h2, 8'hF, OKAY, "wr1");
        axi_write(8'h08, 64'h3, 8'hF, OKAY, "wr2");
        axi_write(8'h0C, 64'h4, 8'hF, OKAY, "wr3");
        chk("pulse_once", pulse_delta(), 64'h0000_0000_0101_0101);
        axi_read(8'h00, 64'h1, OKAY, "rd0");
        axi_read(8'h04, 64'h2, OKAY, "rd1");
        axi_read(8'h08, 64'h3, OKAY, "rd2");
        axi_read(8'h0C, 64'h4, OKAY, "rd3");

        // Bank A: W leads AW by three cycles, partial strobe.
        axi_write(8'h10, 64'h1122_3344, 8'hF, OKAY, "wr4_init");
        exp_b.push_back(OKAY);
        w_data = 64'hDEAD_BEEF; w_strb = 8'h3; w_valid = 1'b1;
        chk("w_first_ready", 64'(wready), 64'(1));
        step();
        w_valid = 1'b0;
        step();
        step();
        aw_addr = 8'h10; aw_valid = 1'b1;
        chk("aw_late_ready", 64'(awready), 64'(1));
        step();
        aw_valid = 1'b0;
        chk("b_not_early", 64'(bvalid), 64'(0));
        step();
        chk("b_one_cycle", 64'(bvalid), 64'(1));
        b_collect("wr4_merge");
        chk("r4_merged", regv[4], 64'h1122_BEEF);
        axi_read(8'h10, 64'h1122_BEEF, OKAY, "rd4");

        // Bank A: out-of-range read and write.
        take_snap();
        axi_read(8'h40, 64'h0, SLVERR, "rd_oor");
        axi_write(8'h44, 64'hFFFF_FFFF, 8'hF, SLVERR, "wr_oor");
        chk("oor_no_pulse", pulse_delta(), 64'(0));
        chk("oor_regs_lo", {regv[3][15:0], regv[2][15:0], regv[1][15:0], regv[0][15:0]},
            64'h0004_0003_0002_0001);
        chk("oor_regs_hi", {regv[7][15:0], regv[6][15:0], regv[5][15:0], regv[4][15:0]},
            64'h0000_0000_0000_BEEF);

        // Bank B: read-only register rejects AXI writes but takes hardware loads.
        sel = 1;
        #1;
        take_snap();
        axi_write(8'h04, 64'h5, 8'hF, SLVERR, "wr_ro");
        chk("ro_unchanged", regv[1], 64'(0));
        chk("ro_no_pulse", pulse_delta(), 64'(0));
        hw_d32[63:32] = 32'h0000_A5A5; hw_we = 8'h02;
        step();
        hw_we = 8'h00;
        axi_read(8'h04, 64'hA5A5, OKAY, "rd_ro");

        // Bank C (64-bit): AXI commit beats a same-cycle hardware load.
        sel = 2;
        #1;
        exp_b.push_back(OKAY);
        aw_addr = 8'h08; w_data = 64'h0123_4567_89AB_CDEF; w_strb = 8'hFF;
        chk("c_ready", 64'({awready, wready}), 64'(3));
        aw_valid = 1'b1; w_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("c_commit_pulse", 64'(pulse), 64'h02);
        hw_d64[127:64] = 64'h0; hw_we = 8'h02;
        step();
        hw_we = 8'h00;
        chk("c_axi_wins", regv[1], 64'h0123_4567_89AB_CDEF);
        b_collect("wr_c1");
        axi_read(8'h08, 64'h0123_4567_89AB_CDEF, OKAY, "rd_c1");
        hw_d64[191:128] = 64'hCAFE_F00D_1234_5678; hw_we = 8'h04;
        step();
        hw_we = 8'h00;
        chk("c_hw_load_rw", regv[2], 64'hCAFE_F00D_1234_5678);

        // Bank B: B channel stall, then reset with BVALID held.
        sel = 1;
        #1;
        exp_b.push_back(OKAY);
        aw_addr = 8'h00; w_data = 64'h77; w_strb = 8'hF;
        aw_valid = 1'b1; w_valid = 1'b1;
        step();
        aw_valid = 1'b0; w_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", 64'({awready, wready, bvalid}), 64'b001);
            step();
        end
        chk("stall_reg0", regv[0], 64'h77);
        rst = 1'b1;
        step();
        chk("rst_mid_bvalid", 64'(bvalid), 64'(0));
        chk("rst_mid_rw0", regv[0], 64'h5A5A);
        chk("rst_mid_ro1", regv[1], 64'(0));
        exp_b.delete();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grid_axil_regbank.md
Name: grid_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank. It generalises the fixed 4 x 32-bit grid-controller register slice to N registers of 32 or 64 bits, with byte strobes, per-register read-only (status) mode, hardware-side update ports, write-event pulses, and SLVERR on out-of-range access. It sits between the PS AXI interconnect and the grid/display logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, bus and register width; legal values are 32 or 64.
C_S_AXI_ADDR_WIDTH, 6, byte-address width; must be >= clog2(NUM_REGS) + clog2(C_S_AXI_DATA_WIDTH/8).
NUM_REGS, 8, number of registers, 1..64.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only from AXI.
RESET_VAL, 0, per-register reset value for RW registers (same for all).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DW  write data
S_AXI_WSTRB  in  DW/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  OKAY=00, SLVERR=10
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DW  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_q  out  NUM_REGS*DW  flattened register contents; register i at [i*DW +: DW]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse, register i written by AXI
hw_d  in  NUM_REGS*DW  hardware update data
hw_we  in  NUM_REGS  hardware update enable

Behaviour:
- Reset: the reset is synchronous, active-high, on ACLK. All READY/VALID outputs 0, BRESP/RRESP 00, RDATA 0, reg_wr_pulse 0, RW registers = RESET_VAL, RO registers = 0. Reset mid-transaction drops any held AW/W/B/AR/R state with no response.
- Write path, one outstanding write:
  - AWREADY=1 while no AW is held and BVALID=0; WREADY=1 while no W is held and BVALID=0.
  - AW and W are accepted independently, in either order or the same cycle, and latched.
  - The cycle after both are held: commit, BVALID=1, both holds cleared. Latency is 1 cycle from the second handshake to BVALID.
  - BVALID stays asserted until BREADY; no new AW/W is accepted meanwhile.
- Register index = addr >> clog2(DW/8); low address bits are ignored.
  - index >= NUM_REGS: SLVERR, no state change.
  - RW register: for each byte b with WSTRB[b]=1, reg[b] <= WDATA[b]. reg_wr_pulse[i]=1 in the commit cycle, even if WSTRB=0. BRESP OKAY.
  - RO register: no change, no pulse, BRESP SLVERR.
- Hardware port: hw_we[i]=1 loads hw_d into register i every cycle, for both RO and RW registers. On the same register in the same cycle, an AXI commit beats hw_we for RW registers; for RO registers hw_we always applies.
- Read path, one outstanding read:
  - ARREADY=1 while RVALID=0.
  - RVALID=1 the cycle after the AR handshake, holding the register value sampled at that handshake.
  - Out of range: RDATA=0, RRESP=SLVERR. RO and RW reads both return OKAY.
  - RVALID/RDATA hold until RREADY.
- Read and write paths are independent. A read and a commit to the same register in the same cycle return the old value.
- reg_q is combinationally equal to the register array (zero output latency).

Decomposition:
- Package grid_axil_pkg: RESP_OKAY and RESP_SLVERR constants, plus a helper function for the index-width calculation.
- One sub-module, grid_axil_wstrb_merge: combinational byte-merge of old data, WDATA and WSTRB. Instantiate it once per bank, not per register, by muxing in the selected register.

Test Plan:
- Defaults, write 1,2,3,4 to 0x0,0x4,0x8,0xC, then read back -> OKAY, data 0x00000001..0x00000004; reg_wr_pulse[0..3] each pulses once.
- W presented 3 cycles before AW to 0x10, data 0xDEADBEEF, WSTRB=0x3 over prior 0x11223344 -> register 4 = 0x1122BEEF; BVALID exactly 1 cycle after the AW handshake.
- RO_MASK=0x02, write 0x5 to 0x4 -> SLVERR, register unchanged, no pulse. With hw_we[1]=1, hw_d=0xA5A5 -> read 0x4 returns 0x0000A5A5, OKAY.
- NUM_REGS=8, read 0x40 and write 0x44 -> SLVERR on both, RDATA=0, no register change.
- DW=64, write 0x0123456789ABCDEF to 0x8 -> register 1 holds it; hw_we[1] in the commit cycle with hw_d=0 -> register still 0x0123456789ABCDEF.
- BREADY held low 10 cycles -> AWREADY/WREADY stay 0 and BVALID stays 1. Assert ARESET with BVALID high -> BVALID=0 and registers = RESET_VAL the next cycle.
